// File: rtl/mul_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mul_pkg                                                    |
// | Purpose  : Shared types and constants for the shift-add multiplier:   |
// |            FSM state encoding, NZCV bit positions, iteration count,   |
// |            no-write destination code and a flag-update helper.        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int MUL_ITERATIONS = 32;
    localparam int CNT_W          = $clog2(MUL_ITERATIONS);

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Destination code that the register file treats as "no write"
    localparam logic [3:0] NO_WRITE_SEL = 4'b1111;

    // N and Z follow the result when flag update is requested; C and V always pass through
    function automatic logic [3:0] mul_flags(input logic [31:0] value,
                                             input logic        update,
                                             input logic [3:0]  flags_in);
        logic [3:0] f;
        f = flags_in;
        if (update) begin
            f[FLAG_N] = value[31];
            f[FLAG_Z] = (value == 32'd0);
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mul_unit                                                   |
// | Purpose  : Iterative 32x32 -> 32 shift-add multiplier with optional   |
// |            accumulate (MUL / MLA) and NZ flag update. One bit of the  |
// |            multiplier is consumed per RUN cycle.                      |
// | Options  : MUL_EARLY_TERM_EN - finish as soon as the remaining        |
// |            multiplier bits are all zero.                              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module mul_unit (
    input  logic        clock,
    input  logic        not_reset,
    input  logic        start,
    input  logic [31:0] op_m,
    input  logic [31:0] op_s,
    input  logic [31:0] op_n,
    input  logic        accumulate,
    input  logic        set_flags,
    input  logic [3:0]  dest_sel,
    input  logic [3:0]  in_flags,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  dest_sel_out,
    output logic [3:0]  out_flags
);
    import mul_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERATIONS - 1);

    mul_state_t        state;
    mul_state_t        next_state;

    logic [31:0]       mcand;
    logic [31:0]       mplier;
    logic [31:0]       acc;
    logic [CNT_W-1:0]  count;
    logic [3:0]        dest_q;
    logic [3:0]        flags_q;
    logic              set_flags_q;

    logic [31:0]       acc_sum;
    logic [31:0]       mplier_shift;
    logic              last_iter;
    logic              accept;

    // One shift-add step: conditional add of the multiplicand, 32-bit wrap
    always_comb begin
        acc_sum      = mplier[0] ? (acc + mcand) : acc;
        mplier_shift = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
        last_iter    = (count == LAST_ITER) || (mplier_shift == 32'd0);
`else
        last_iter    = (count == LAST_ITER);
`endif
        accept       = start && (state != ST_RUN);
    end

    // State register
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        next_state   = state;
        busy         = 1'b0;
        done         = 1'b0;
        dest_sel_out = NO_WRITE_SEL;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                dest_sel_out = dest_q;
                next_state   = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            mcand       <= 32'd0;
            mplier      <= 32'd0;
            acc         <= 32'd0;
            count       <= '0;
            dest_q      <= NO_WRITE_SEL;
            flags_q     <= 4'd0;
            set_flags_q <= 1'b0;
            result      <= 32'd0;
            out_flags   <= 4'd0;
        end else if (accept) begin
            mcand       <= op_m;
            mplier      <= op_s;
            acc         <= accumulate ? op_n : 32'd0;
            count       <= '0;
            dest_q      <= dest_sel;
            flags_q     <= in_flags;
            set_flags_q <= set_flags;
        end else if (state == ST_RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier_shift;
            count  <= count + CNT_W'(1);
            if (last_iter) begin
                result    <= acc_sum;
                out_flags <= mul_flags(acc_sum, set_flags_q, flags_q);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_mul_unit                                                |
// | Purpose  : Self-checking bench for mul_unit against an arithmetic     |
// |            reference (64-bit product, truncated) with random and      |
// |            directed operands, reset abort and back-to-back starts.    |
// | Options  : MUL_EARLY_TERM_EN - expected latency follows the highest   |
// |            set multiplier bit when defined.                           |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_mul_unit;

    logic        clock;
    logic        not_reset;
    logic        start;
    logic [31:0] op_m;
    logic [31:0] op_s;
    logic [31:0] op_n;
    logic        accumulate;
    logic        set_flags;
    logic [3:0]  dest_sel;
    logic [3:0]  in_flags;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  dest_sel_out;
    logic [3:0]  out_flags;

    int vectors;
    int miscompares;

    mul_unit dut (
        .clock       (clock),
        .not_reset   (not_reset),
        .start       (start),
        .op_m        (op_m),
        .op_s        (op_s),
        .op_n        (op_n),
        .accumulate  (accumulate),
        .set_flags   (set_flags),
        .dest_sel    (dest_sel),
        .in_flags    (in_flags),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dest_sel_out(dest_sel_out),
        .out_flags   (out_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-width product plus addend, keep the low word
    function automatic logic [31:0] ref_result(input logic [31:0] m, input logic [31:0] s,
                                               input logic [31:0] n, input logic acc);
        logic [63:0] p;
        p = 64'(m) * 64'(s) + (acc ? 64'(n) : 64'd0);
        return p[31:0];
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] r, input logic sf, input logic [3:0] fl);
        if (sf) return {r[31], (r == 32'd0), fl[1], fl[0]};
        return fl;
    endfunction

    // Edges from start-accept until done is high
    function automatic int ref_latency(input logic [31:0] s);
`ifdef MUL_EARLY_TERM_EN
        int iters;
        iters = 1;
        for (int i = 0; i < 32; i++) if (s[i]) iters = i + 1;
        return iters + 1;
`else
        return 33;
`endif
    endfunction

    task automatic apply(input logic [31:0] m, input logic [31:0] s, input logic [31:0] n,
                         input logic acc, input logic sf, input logic [3:0] d, input logic [3:0] fl);
        op_m = m; op_s = s; op_n = n; accumulate = acc;
        set_flags = sf; dest_sel = d; in_flags = fl;
        start = 1'b1;
    endtask

    // Counts edges from the accept edge until done; optionally pokes a stray start mid-run
    task automatic wait_done(input int poke_at, output int edges);
        edges = 0;
        do begin
            @(posedge clock); #1;
            edges++;
            if (edges == 1) start = 1'b0;
            if (edges == 2) check("busy_in_run", {63'd0, busy}, 64'd1);
            if (edges == poke_at) begin
                start = 1'b1; op_m = $urandom; op_s = $urandom; op_n = $urandom;
                accumulate = 1'b1; dest_sel = 4'd0;
            end
            if (edges == poke_at + 1) start = 1'b0;
        end while (!done && edges < 100);
    endtask

    task automatic run_and_check(input logic [31:0] m, input logic [31:0] s, input logic [31:0] n,
                                 input logic acc, input logic sf, input logic [3:0] d,
                                 input logic [3:0] fl, input int poke_at, input bit chain);
        logic [31:0] er;
        logic [3:0]  ef;
        int          edges;
        er = ref_result(m, s, n, acc);
        ef = ref_flags(er, sf, fl);
        apply(m, s, n, acc, sf, d, fl);
        wait_done(poke_at, edges);
        check("latency",  64'(edges), 64'(ref_latency(s)));
        check("done",     {63'd0, done}, 64'd1);
        check("result",   64'(result), 64'(er));
        check("dest_sel", 64'(dest_sel_out), 64'(d));
        check("flags",    64'(out_flags), 64'(ef));
        if (!chain) begin
            @(posedge clock); #1;
            check("done_pulse", {63'd0, done}, 64'd0);
            check("dest_mask",  64'(dest_sel_out), 64'hF);
            check("result_hold", 64'(result), 64'(er));
        end
    endtask

    initial begin
        int  quiet_edges;
        bit  seen_done;
        logic [31:0] rs;

        vectors = 0; miscompares = 0;
        not_reset = 1'b0; start = 1'b0;
        op_m = '0; op_s = '0; op_n = '0; accumulate = 1'b0;
        set_flags = 1'b0; dest_sel = '0; in_flags = '0;

        #2;
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_done",  {63'd0, done}, 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(out_flags), 64'd0);
        check("rst_dest",  64'(dest_sel_out), 64'hF);
        repeat (3) @(negedge clock);
        not_reset = 1'b1;
        @(posedge clock); #1;

        // Directed arithmetic cases
        run_and_check(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'd4, 4'b1010, 0, 1'b0);
        run_and_check(32'hFFFFFFFF, 32'd2, 32'd1, 1'b1, 1'b1, 4'd7, 4'b0011, 0, 1'b0);
        run_and_check(32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b1, 4'd2, 4'b0000, 0, 1'b0);
        run_and_check(32'd9, 32'd1, 32'd0, 1'b0, 1'b0, 4'd1, 4'b0101, 0, 1'b0);
        run_and_check(32'h12345678, 32'd0, 32'd0, 1'b0, 1'b1, 4'd3, 4'b0010, 0, 1'b0);

        // Reset asserted on RUN edge 10 aborts the operation
        apply(32'd11, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 4'd5, 4'd0);
        @(posedge clock); #1; start = 1'b0;
        repeat (9) @(posedge clock);
        #2 not_reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_dest", 64'(dest_sel_out), 64'hF);
        check("abort_result", 64'(result), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); not_reset = 1'b1;
        seen_done = 1'b0;
        for (quiet_edges = 0; quiet_edges < 40; quiet_edges++) begin
            @(posedge clock); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", {63'd0, seen_done}, 64'd0);
        run_and_check(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'd6, 4'd0, 0, 1'b0);

        // Stray start during RUN ignored, then start held in DONE chains a second op
        run_and_check(32'hDEADBEEF, 32'h80000001, 32'h1000, 1'b1, 1'b1, 4'd9, 4'b0001, 5, 1'b1);
        run_and_check(32'h0000ABCD, 32'h00001234, 32'd0, 1'b0, 1'b1, 4'd10, 4'b1100, 0, 1'b0);

        // Randomized operands, with a bias toward short multipliers
        for (int i = 0; i < 25; i++) begin
            rs = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            run_and_check($urandom, rs, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)), 0,
                          1'($urandom_range(0, 1)));
        end
        @(posedge clock); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
